// File: rtl/mpu6050_pkg.sv
// Shared MPU6050 constants, reader FSM encoding and sample container type.
package mpu6050_pkg;

  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [6:0] MPU6050_ADDR = 7'h68;

  localparam int NUM_BYTES = 6;

  typedef logic [2:0] state_t;

  localparam state_t StIdle       = 3'd0;
  localparam state_t StWaitPeriod = 3'd1;
  localparam state_t StReq        = 3'd2;
  localparam state_t StCollect    = 3'd3;
  localparam state_t StStopReq    = 3'd4;
  localparam state_t StPublish    = 3'd5;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } accel_t;

  // The sensor supplies each axis high byte first.
  function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mpu6050_reader_if.sv
// Command/byte-stream link between the MPU6050 reader and i2c_master.
interface mpu6050_reader_if;

  logic       i2c_avail;
  logic [7:0] i2c_data;
  logic       i2c_data_valid;
  logic       i2c_start;
  logic       i2c_stop;
  logic [6:0] i2c_slave_address;
  logic [7:0] i2c_reg_addr;

  modport master (
    input  i2c_avail,
    input  i2c_data,
    input  i2c_data_valid,
    output i2c_start,
    output i2c_stop,
    output i2c_slave_address,
    output i2c_reg_addr
  );

  modport slave (
    output i2c_avail,
    output i2c_data,
    output i2c_data_valid,
    input  i2c_start,
    input  i2c_stop,
    input  i2c_slave_address,
    input  i2c_reg_addr
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for a slow-domain level, with a one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/mpu6050_reader.sv
// Periodic burst reader of the MPU6050 accelerometer registers via i2c_master;
// publishes three big-endian signed axis values with a one-cycle strobe.
module mpu6050_reader
  import mpu6050_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR    = MPU6050_ADDR,
  parameter logic [7:0]  START_REG     = ACCEL_XOUT_H,
  parameter int unsigned SAMPLE_PERIOD = 500000,
  parameter int unsigned TIMEOUT       = 2000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  mpu6050_reader_if.master        i2c_bus,
  output logic [15:0]             accel_x,
  output logic [15:0]             accel_y,
  output logic [15:0]             accel_z,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_period;
  logic [TW-1:0] r_tmo;
  logic [2:0]    r_idx;
  logic [7:0]    r_shadow [NUM_BYTES];
  logic          r_success;
  accel_t        r_accel;
  logic          r_sample_valid;
  logic          r_timeout_err;
  logic          r_avail_meta;
  logic          r_avail_sync;
  logic          w_byte_evt;
  logic          w_timeout;
  logic          w_enter_req;
  logic          w_store;

  sync_edge_detect u_valid_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (i2c_bus.i2c_data_valid),
    .o_rise  (w_byte_evt)
  );

  // avail only needs its level, so it gets a plain two-flop synchronizer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_avail_meta <= 1'b0;
      r_avail_sync <= 1'b0;
    end else begin
      r_avail_meta <= i2c_bus.i2c_avail;
      r_avail_sync <= r_avail_meta;
    end
  end

  assign w_timeout = ((r_state == StReq) || (r_state == StCollect)) && (r_tmo == TIMEOUT_LAST);
  assign w_store   = (r_state == StCollect) && w_byte_evt && !w_timeout;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (enable && r_avail_sync) w_state_next = StReq;
      end
      StWaitPeriod: begin
        if (!enable) w_state_next = StIdle;
        else if ((r_period == PERIOD_LAST) && r_avail_sync) w_state_next = StReq;
      end
      StReq: begin
        if (w_timeout) w_state_next = StStopReq;
        else if (!r_avail_sync) w_state_next = StCollect;
      end
      StCollect: begin
        if (w_timeout) w_state_next = StStopReq;
        else if (w_byte_evt && (r_idx == 3'd5)) w_state_next = StStopReq;
      end
      StStopReq: begin
        if (r_avail_sync) w_state_next = r_success ? StPublish : StWaitPeriod;
      end
      StPublish: begin
        w_state_next = enable ? StWaitPeriod : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_enter_req = (w_state_next == StReq) && (r_state != StReq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Free-running period counter phased to REQ entry; overrunning periods are skipped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period <= '0;
    end else if (w_enter_req || (r_period == PERIOD_LAST)) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (w_enter_req) begin
      r_tmo <= '0;
    end else if ((r_state == StReq) || (r_state == StCollect)) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx     <= 3'd0;
      r_success <= 1'b0;
    end else if (w_enter_req) begin
      r_idx     <= 3'd0;
      r_success <= 1'b0;
    end else if (w_timeout) begin
      r_success <= 1'b0;
    end else if (w_store) begin
      if (r_idx == 3'd5) r_success <= 1'b1;
      else               r_idx     <= r_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BYTES; i++) r_shadow[i] <= 8'h00;
    end else if (w_store) begin
      r_shadow[r_idx] <= i2c_bus.i2c_data;
    end
  end

  // Axis values only ever change together, so consumers never see a torn sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_accel        <= '0;
      r_sample_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_sample_valid <= (r_state == StPublish);
      if (r_state == StPublish) begin
        r_accel.x     <= be16(r_shadow[0], r_shadow[1]);
        r_accel.y     <= be16(r_shadow[2], r_shadow[3]);
        r_accel.z     <= be16(r_shadow[4], r_shadow[5]);
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign i2c_bus.i2c_start         = (r_state == StReq);
  assign i2c_bus.i2c_stop          = (r_state == StStopReq);
  assign i2c_bus.i2c_slave_address = SLAVE_ADDR;
  assign i2c_bus.i2c_reg_addr      = START_REG;

  assign accel_x      = r_accel.x;
  assign accel_y      = r_accel.y;
  assign accel_z      = r_accel.z;
  assign sample_valid = r_sample_valid;
  assign timeout_err  = r_timeout_err;
  assign busy         = (r_state != StIdle) && (r_state != StWaitPeriod);

endmodule

// File: doc/mpu6050_reader.md
Name: mpu6050_reader

Overview:
- Sequencer that sits directly above i2c_master in the MPU6050 sensor path.
- Periodically commands a burst read of accelerometer registers 0x3B..0x40 and consumes the byte stream from i2c_master.
- Assembles the bytes into three signed 16-bit axis values and presents them to the game logic with a one-cycle valid strobe.

Parameters:
- SLAVE_ADDR, 7'h68, MPU6050 I2C address driven to i2c_master.
- START_REG, 8'h3B, first register of the burst (ACCEL_XOUT_H).
- SAMPLE_PERIOD, 500000, clk cycles from the start of one sample request to the start of the next (10 ms at 50 MHz).
- TIMEOUT, 2000000, max clk cycles allowed from request to 6th byte.

Ports:
- clk  in  1  system clock (same clock that feeds i2c_master).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = sample continuously; 0 = finish the current transaction, then idle.
- i2c_avail  in  1  from i2c_master avail_i2c_master (1 = master idle).
- i2c_data  in  8  from i2c_master data_out.
- i2c_data_valid  in  1  from i2c_master avail_data_out; level, held for several clk cycles per byte.
- i2c_start  out  1  to i2c_master start.
- i2c_stop  out  1  to i2c_master stop.
- i2c_slave_address  out  7  constant SLAVE_ADDR.
- i2c_reg_addr  out  8  constant START_REG (to i2c_master data_in).
- accel_x  out  16  signed, {byte0, byte1}.
- accel_y  out  16  signed, {byte2, byte3}.
- accel_z  out  16  signed, {byte4, byte5}.
- sample_valid  out  1  one-cycle pulse when accel_* update.
- busy  out  1  1 in any state except IDLE and WAIT_PERIOD.
- timeout_err  out  1  sticky; set on timeout, cleared on the next successful sample.

Behaviour:
- Reset (async, reset==0):
  - All outputs and registers go to 0, except i2c_slave_address and i2c_reg_addr, which are constants.
  - FSM enters IDLE.
- Input conditioning:
  - i2c_avail and i2c_data_valid each pass through a 2-flop synchronizer, because i2c_master updates them on a derived clock.
  - A byte event is a rising edge of the synchronized data_valid.
  - On a byte event, i2c_data is sampled in that same cycle. It is stable while avail_data_out is high.
- Period counter: counts clk cycles and reloads to 0 when REQ is entered.
- FSM states:
  - IDLE: all outputs low. Go to REQ when enable==1 and synced avail==1.
  - WAIT_PERIOD: go to REQ when period counter == SAMPLE_PERIOD-1 and synced avail==1. Go to IDLE if enable==0.
  - REQ: i2c_start=1 and timeout counter cleared. Go to COLLECT on the first cycle synced avail==0.
  - COLLECT:
    - i2c_start=0; byte index 0..5 increments on each byte event.
    - Each byte is stored in shadow register [index].
    - After the byte at index 5, go to STOP_REQ with the success flag set.
  - STOP_REQ: i2c_stop=1. Hold until synced avail==1, then go to PUBLISH on success, else to WAIT_PERIOD.
  - PUBLISH:
    - Single cycle: copy shadows to accel_x/y/z, pulse sample_valid, clear timeout_err.
    - Then go to WAIT_PERIOD if enable==1, else IDLE.
- Timeout:
  - In REQ and COLLECT, a counter increments every clk.
  - At TIMEOUT-1, set timeout_err, clear the success flag and go to STOP_REQ.
  - accel_* keep their previous values.
- Output updates: accel_x/y/z change only in PUBLISH, so they are never partially updated.
- enable falling mid-transaction: the transaction completes normally (including PUBLISH), then the FSM goes to IDLE.
- Byte event in the same cycle as the timeout: timeout wins and the byte is discarded.
- Extra byte events in STOP_REQ: ignored.
- If SAMPLE_PERIOD elapses while a transaction is still running, that period is skipped. The next request waits for the next full period from REQ entry.
- Widths:
  - Byte index: 3 bits.
  - Period and timeout counters: $clog2 of the respective parameter.
  - No arithmetic on data: values are pure concatenations, big-endian as the MPU6050 supplies them.

Decomposition:
- Shared package mpu6050_pkg holds:
  - MPU6050 register constants (ACCEL_XOUT_H=8'h3B, GYRO_XOUT_H=8'h43, PWR_MGMT_1=8'h6B);
  - default address 7'h68;
  - FSM state encoding localparams.
- One sub-module, sync_edge_detect: 2-flop synchronizer plus rising-edge pulse, instantiated for data_valid. A level-only variant is used for avail.

Test Plan:
- i2c_master behavioural model returns 0x12,0x34,0xFF,0x38,0x00,0x01 with enable=1.
  - Required: i2c_start held high until avail drops, then stop asserted once.
  - Required: accel_x=0x1234, accel_y=0xFF38 (-200), accel_z=0x0001.
  - Required: sample_valid high exactly 1 cycle.
- Two consecutive samples with SAMPLE_PERIOD=1000.
  - Required: second start rising edge exactly 1000 clk after the first REQ entry.
  - Required: accel_* unchanged between PUBLISH pulses.
- Model sends only 3 bytes, with TIMEOUT=5000.
  - Required: timeout_err=1 at cycle 5000 and stop asserted.
  - Required: no sample_valid; accel_* retain 0x1234/0xFF38/0x0001.
  - Required: the next good read clears timeout_err.
- Set enable=0 after byte 2.
  - Required: bytes 3-6 still collected and PUBLISH occurs.
  - Required: FSM returns to IDLE with i2c_start=0 and no further request.
- Reset pulled low during COLLECT (byte index 4).
  - Required: all outputs 0 immediately (asynchronous), i2c_start/i2c_stop=0.
  - Required: after reset release with enable=1, a full fresh transaction.
- data_valid held high 40 clk per byte.
  - Required: each byte is counted once, not repeatedly.
